// File: rtl/usb1_reg_arb.sv
// ---------------------------------------------------------------------------
// usb1_reg_arb
//
// Purpose:
//   Arbitrates two register masters onto the single usbh_core register
//   port. Master 0 is the wishbone bridge. Master 1 is the autonomous
//   poll engine. Each master gets one outstanding transfer. Arbitration
//   between the masters is round-robin. Every slave transfer is guarded
//   by a cycle timeout, so a stuck slave turns into an error response
//   and the bus is not lost.
//
// Parameters:
//   AW   register address width
//   TMO  slave-ack timeout in cycles (legal range 2..65535)
//
// Ports:
//   usb_clk_i, usb_rstn_i        clock, asynchronous active-low reset
//   m0_* / m1_*                  master request (cs, wr, addr, wdata, be)
//                                and response (rdata, ack, err)
//   s_cs, s_wr, s_addr,
//   s_wdata, s_be                slave request, held stable while BUSY
//   s_rdata, s_ack               slave response
//   tmo_cnt                      saturating count of timed-out transfers
//   busy                         FSM is not IDLE
// ---------------------------------------------------------------------------
module usb1_reg_arb #(
  parameter int AW  = 6,
  parameter int TMO = 255
) (
  input  logic          usb_clk_i,
  input  logic          usb_rstn_i,

  input  logic          m0_cs,
  input  logic          m0_wr,
  input  logic [AW-1:0] m0_addr,
  input  logic [31:0]   m0_wdata,
  input  logic [3:0]    m0_be,
  output logic [31:0]   m0_rdata,
  output logic          m0_ack,
  output logic          m0_err,

  input  logic          m1_cs,
  input  logic          m1_wr,
  input  logic [AW-1:0] m1_addr,
  input  logic [31:0]   m1_wdata,
  input  logic [3:0]    m1_be,
  output logic [31:0]   m1_rdata,
  output logic          m1_ack,
  output logic          m1_err,

  output logic          s_cs,
  output logic          s_wr,
  output logic [AW-1:0] s_addr,
  output logic [31:0]   s_wdata,
  output logic [3:0]    s_be,
  input  logic [31:0]   s_rdata,
  input  logic          s_ack,

  output logic [7:0]    tmo_cnt,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  // The counter starts at 0 on the first BUSY cycle. So the timeout fires
  // at the end of the TMO-th BUSY cycle.
  localparam logic [15:0] TMO_LAST = 16'(TMO - 1);

  state_t          r_state;
  logic            r_last_grant;  // 0 = m0, 1 = m1; also the current owner while BUSY/RESP
  logic [15:0]     r_cnt;
  logic            r_drop;        // granted master released cs during an earlier BUSY cycle
  logic [7:0]      r_tmo_cnt;

  logic            r_s_cs;
  logic            r_s_wr;
  logic [AW-1:0]   r_s_addr;
  logic [31:0]     r_s_wdata;
  logic [3:0]      r_s_be;

  logic [31:0]     r_m0_rdata;
  logic            r_m0_ack;
  logic            r_m0_err;
  logic [31:0]     r_m1_rdata;
  logic            r_m1_ack;
  logic            r_m1_err;

  logic            w_any_req;
  logic            w_win;
  logic            w_sel_wr;
  logic [AW-1:0]   w_sel_addr;
  logic [31:0]     w_sel_wdata;
  logic [3:0]      w_sel_be;
  logic            w_gnt_cs;
  logic            w_discard;
  logic            w_tmo;

  // Round-robin: one requester always wins. When both request, the master
  // that did not win last time gets the grant.
  assign w_any_req   = m0_cs | m1_cs;
  assign w_win       = (m0_cs & m1_cs) ? ~r_last_grant : m1_cs;

  assign w_sel_wr    = w_win ? m1_wr    : m0_wr;
  assign w_sel_addr  = w_win ? m1_addr  : m0_addr;
  assign w_sel_wdata = w_win ? m1_wdata : m0_wdata;
  assign w_sel_be    = w_win ? m1_be    : m0_be;

  // The owner's cs is watched only to decide whether its response is still
  // wanted. Its request fields are never re-sampled after the grant.
  assign w_gnt_cs    = r_last_grant ? m1_cs : m0_cs;
  assign w_discard   = r_drop | ~w_gnt_cs;
  assign w_tmo       = (r_cnt == TMO_LAST);

  always_ff @(posedge usb_clk_i or negedge usb_rstn_i) begin
    if (!usb_rstn_i) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b1;
      r_cnt        <= 16'd0;
      r_drop       <= 1'b0;
      r_tmo_cnt    <= 8'd0;
      r_s_cs       <= 1'b0;
      r_s_wr       <= 1'b0;
      r_s_addr     <= '0;
      r_s_wdata    <= 32'd0;
      r_s_be       <= 4'd0;
      r_m0_rdata   <= 32'd0;
      r_m0_ack     <= 1'b0;
      r_m0_err     <= 1'b0;
      r_m1_rdata   <= 32'd0;
      r_m1_ack     <= 1'b0;
      r_m1_err     <= 1'b0;
    end else begin
      // The ack and err pulses last only one cycle. They are raised only
      // on the BUSY->RESP transition.
      r_m0_ack <= 1'b0;
      r_m0_err <= 1'b0;
      r_m1_ack <= 1'b0;
      r_m1_err <= 1'b0;

      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_last_grant <= w_win;
            r_s_cs       <= 1'b1;
            r_s_wr       <= w_sel_wr;
            r_s_addr     <= w_sel_addr;
            r_s_wdata    <= w_sel_wdata;
            r_s_be       <= w_sel_be;
            r_cnt        <= 16'd0;
            r_drop       <= 1'b0;
            r_state      <= BUSY;
          end
        end

        BUSY: begin
          // s_ack is checked before the timeout. So a late ack that arrives
          // on the timeout cycle still counts as a normal completion.
          if (s_ack) begin
            r_s_cs  <= 1'b0;
            r_state <= RESP;
            if (!w_discard) begin
              if (r_last_grant) begin
                r_m1_rdata <= s_rdata;
                r_m1_ack   <= 1'b1;
              end else begin
                r_m0_rdata <= s_rdata;
                r_m0_ack   <= 1'b1;
              end
            end
          end else if (w_tmo) begin
            r_s_cs  <= 1'b0;
            r_state <= RESP;
            if (r_tmo_cnt != 8'hFF) begin
              r_tmo_cnt <= r_tmo_cnt + 8'd1;
            end
            if (!w_discard) begin
              if (r_last_grant) begin
                r_m1_rdata <= 32'd0;
                r_m1_ack   <= 1'b1;
                r_m1_err   <= 1'b1;
              end else begin
                r_m0_rdata <= 32'd0;
                r_m0_ack   <= 1'b1;
                r_m0_err   <= 1'b1;
              end
            end
          end else begin
            r_cnt  <= r_cnt + 16'd1;
            r_drop <= w_discard;
          end
        end

        RESP: begin
          r_state <= IDLE;
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign s_cs     = r_s_cs;
  assign s_wr     = r_s_wr;
  assign s_addr   = r_s_addr;
  assign s_wdata  = r_s_wdata;
  assign s_be     = r_s_be;

  assign m0_rdata = r_m0_rdata;
  assign m0_ack   = r_m0_ack;
  assign m0_err   = r_m0_err;
  assign m1_rdata = r_m1_rdata;
  assign m1_ack   = r_m1_ack;
  assign m1_err   = r_m1_err;

  assign tmo_cnt  = r_tmo_cnt;
  assign busy     = (r_state != IDLE);

endmodule

// File: tb/tb_usb1_reg_arb.sv
// ---------------------------------------------------------------------------
// tb_usb1_reg_arb
//
// Purpose:
//   Directed bench for usb1_reg_arb with TMO=8. Inputs are driven on the
//   falling clock edge and outputs are sampled on the falling clock edge.
//   So one tick() covers exactly one rising edge of the DUT. All expected
//   values are written by hand from the cycle timing:
//     request in IDLE -> s_cs on the next tick
//     ack in BUSY     -> RESP (mN_ack) on the next tick
//     RESP            -> IDLE on the next tick
// ---------------------------------------------------------------------------
module tb_usb1_reg_arb;

  logic        usb_clk_i = 1'b0;
  logic        usb_rstn_i = 1'b1;
  logic        m0_cs = 1'b0, m0_wr = 1'b0;
  logic [5:0]  m0_addr = '0;
  logic [31:0] m0_wdata = '0;
  logic [3:0]  m0_be = '0;
  logic [31:0] m0_rdata;
  logic        m0_ack, m0_err;
  logic        m1_cs = 1'b0, m1_wr = 1'b0;
  logic [5:0]  m1_addr = '0;
  logic [31:0] m1_wdata = '0;
  logic [3:0]  m1_be = '0;
  logic [31:0] m1_rdata;
  logic        m1_ack, m1_err;
  logic        s_cs, s_wr;
  logic [5:0]  s_addr;
  logic [31:0] s_wdata;
  logic [3:0]  s_be;
  logic [31:0] s_rdata = '0;
  logic        s_ack = 1'b0;
  logic [7:0]  tmo_cnt;
  logic        busy;

  int checks = 0;
  int errors = 0;

  usb1_reg_arb #(.AW(6), .TMO(8)) dut (
    .usb_clk_i (usb_clk_i),
    .usb_rstn_i(usb_rstn_i),
    .m0_cs     (m0_cs),
    .m0_wr     (m0_wr),
    .m0_addr   (m0_addr),
    .m0_wdata  (m0_wdata),
    .m0_be     (m0_be),
    .m0_rdata  (m0_rdata),
    .m0_ack    (m0_ack),
    .m0_err    (m0_err),
    .m1_cs     (m1_cs),
    .m1_wr     (m1_wr),
    .m1_addr   (m1_addr),
    .m1_wdata  (m1_wdata),
    .m1_be     (m1_be),
    .m1_rdata  (m1_rdata),
    .m1_ack    (m1_ack),
    .m1_err    (m1_err),
    .s_cs      (s_cs),
    .s_wr      (s_wr),
    .s_addr    (s_addr),
    .s_wdata   (s_wdata),
    .s_be      (s_be),
    .s_rdata   (s_rdata),
    .s_ack     (s_ack),
    .tmo_cnt   (tmo_cnt),
    .busy      (busy)
  );

  // 100 MHz free-running clock
  always #5 usb_clk_i = ~usb_clk_i;

  task automatic tick();
    @(negedge usb_clk_i);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drives the request fields of master m (0 or 1).
  task automatic applyStimulus(input int m, input logic cs, input logic wr,
                               input logic [5:0] addr, input logic [31:0] wdata,
                               input logic [3:0] be);
    if (m == 0) begin
      m0_cs = cs; m0_wr = wr; m0_addr = addr; m0_wdata = wdata; m0_be = be;
    end else begin
      m1_cs = cs; m1_wr = wr; m1_addr = addr; m1_wdata = wdata; m1_be = be;
    end
  endtask

  // One m1 read that the slave never acks: 8 BUSY ticks, then RESP.
  // cs is released in the ack cycle.
  task automatic runTimeoutM1();
    applyStimulus(1, 1'b1, 1'b0, 6'h03, 32'h0, 4'hF);
    repeat (9) tick();
    m1_cs = 1'b0;
    tick();
  endtask

  initial begin
    // ---------------- reset values ----------------
    #1 usb_rstn_i = 1'b0;
    #1;
    checkOutput("rst_s_cs", s_cs, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_m0_ack", m0_ack, 0);
    checkOutput("rst_m1_err", m1_err, 0);
    checkOutput("rst_m0_rdata", m0_rdata, 0);
    checkOutput("rst_tmo_cnt", tmo_cnt, 0);
    checkOutput("rst_s_addr", s_addr, 0);
    tick();
    tick();
    usb_rstn_i = 1'b1;
    tick();

    // ---------------- m0 read, slave acks after 3 BUSY cycles ----------------
    applyStimulus(0, 1'b1, 1'b0, 6'h04, 32'h0, 4'hF);
    checkOutput("rd_s_cs_not_yet", s_cs, 0);
    tick();
    checkOutput("rd_s_cs", s_cs, 1);
    checkOutput("rd_s_addr", s_addr, 32'h04);
    checkOutput("rd_s_wr", s_wr, 0);
    checkOutput("rd_busy", busy, 1);
    tick();
    tick();
    tick();
    checkOutput("rd_no_early_ack", m0_ack, 0);
    s_ack = 1'b1; s_rdata = 32'hA5A5_0001;
    tick();
    checkOutput("rd_m0_ack", m0_ack, 1);
    checkOutput("rd_m0_rdata", m0_rdata, 32'hA5A5_0001);
    checkOutput("rd_m0_err", m0_err, 0);
    checkOutput("rd_m1_ack", m1_ack, 0);
    checkOutput("rd_s_cs_drop", s_cs, 0);
    m0_cs = 1'b0; s_ack = 1'b0;
    tick();
    checkOutput("rd_m0_ack_1cyc", m0_ack, 0);
    checkOutput("rd_idle", busy, 0);

    // ---------------- round-robin after a fresh reset ----------------
    usb_rstn_i = 1'b0;
    tick();
    usb_rstn_i = 1'b1;
    tick();
    applyStimulus(0, 1'b1, 1'b0, 6'h01, 32'h0, 4'hF);
    applyStimulus(1, 1'b1, 1'b0, 6'h02, 32'h0, 4'hF);
    s_ack = 1'b1; s_rdata = 32'hC0DE_0000;   // ack held: ignored outside BUSY
    for (int j = 0; j < 4; j++) begin
      tick();
      checkOutput("rr_s_cs", s_cs, 1);
      checkOutput("rr_s_addr", s_addr, j[0] ? 32'h02 : 32'h01);
      tick();
      checkOutput("rr_m0_ack", m0_ack, {31'd0, ~j[0]});
      checkOutput("rr_m1_ack", m1_ack, {31'd0, j[0]});
      if (j == 3) begin
        m0_cs = 1'b0; m1_cs = 1'b0; s_ack = 1'b0;
      end
      tick();
      checkOutput("rr_idle_m0_ack", m0_ack, 0);
      checkOutput("rr_idle_m1_ack", m1_ack, 0);
    end
    checkOutput("rr_done_busy", busy, 0);
    checkOutput("rr_m0_rdata", m0_rdata, 32'hC0DE_0000);

    // ---------------- m1 timeout, slave never acks ----------------
    applyStimulus(1, 1'b1, 1'b0, 6'h03, 32'h0, 4'hF);
    repeat (8) tick();
    checkOutput("to_s_cs_8th", s_cs, 1);
    checkOutput("to_no_err_yet", m1_err, 0);
    tick();
    checkOutput("to_s_cs_drop", s_cs, 0);
    checkOutput("to_m1_ack", m1_ack, 1);
    checkOutput("to_m1_err", m1_err, 1);
    checkOutput("to_m1_rdata", m1_rdata, 0);
    checkOutput("to_tmo_cnt", tmo_cnt, 1);
    checkOutput("to_m0_ack", m0_ack, 0);
    m1_cs = 1'b0;
    tick();
    checkOutput("to_m1_ack_1cyc", m1_ack, 0);
    checkOutput("to_m1_err_1cyc", m1_err, 0);

    // ---------------- s_ack on the exact timeout cycle ----------------
    applyStimulus(0, 1'b1, 1'b0, 6'h05, 32'h0, 4'hF);
    repeat (8) tick();
    checkOutput("race_s_cs", s_cs, 1);
    s_ack = 1'b1; s_rdata = 32'h5A5A_0021;
    tick();
    checkOutput("race_m0_ack", m0_ack, 1);
    checkOutput("race_m0_err", m0_err, 0);
    checkOutput("race_m0_rdata", m0_rdata, 32'h5A5A_0021);
    checkOutput("race_tmo_cnt", tmo_cnt, 1);
    s_ack = 1'b0; m0_cs = 1'b0;
    tick();

    // ---------------- saturating timeout counter ----------------
    repeat (253) runTimeoutM1();
    checkOutput("sat_tmo_254", tmo_cnt, 32'hFE);
    repeat (46) runTimeoutM1();
    checkOutput("sat_tmo_300", tmo_cnt, 32'hFF);

    // ---------------- m0 write, cs dropped on 2nd BUSY cycle ----------------
    applyStimulus(0, 1'b1, 1'b1, 6'h10, 32'h1234_5678, 4'hC);
    tick();
    checkOutput("wr_s_cs", s_cs, 1);
    checkOutput("wr_s_wr", s_wr, 1);
    checkOutput("wr_s_wdata", s_wdata, 32'h1234_5678);
    checkOutput("wr_s_be", s_be, 32'hC);
    m0_wdata = 32'hDEAD_BEEF; m0_addr = 6'h3F;
    tick();
    m0_cs = 1'b0;
    checkOutput("wr_s_wdata_b2", s_wdata, 32'h1234_5678);
    checkOutput("wr_s_addr_b2", s_addr, 32'h10);
    tick();
    checkOutput("wr_s_cs_b3", s_cs, 1);
    checkOutput("wr_s_be_b3", s_be, 32'hC);
    tick();
    checkOutput("wr_s_wdata_b4", s_wdata, 32'h1234_5678);
    s_ack = 1'b1; s_rdata = 32'h7777_7777;
    tick();
    checkOutput("wr_s_cs_drop", s_cs, 0);
    checkOutput("wr_resp_busy", busy, 1);
    checkOutput("wr_no_m0_ack", m0_ack, 0);
    checkOutput("wr_no_m0_err", m0_err, 0);
    checkOutput("wr_m0_rdata_kept", m0_rdata, 32'h5A5A_0021);
    s_ack = 1'b0;
    tick();
    checkOutput("wr_idle", busy, 0);
    checkOutput("wr_no_m0_ack_late", m0_ack, 0);

    // ---------------- reset pulse during BUSY ----------------
    applyStimulus(1, 1'b1, 1'b0, 6'h07, 32'h0, 4'hF);
    tick();
    tick();
    checkOutput("ar_s_cs_before", s_cs, 1);
    #2 usb_rstn_i = 1'b0;
    #1;
    checkOutput("ar_s_cs_async", s_cs, 0);
    checkOutput("ar_busy_async", busy, 0);
    checkOutput("ar_tmo_cnt", tmo_cnt, 0);
    checkOutput("ar_m1_rdata", m1_rdata, 0);
    m1_cs = 1'b0;
    tick();
    checkOutput("ar_no_m1_ack", m1_ack, 0);
    usb_rstn_i = 1'b1;
    tick();
    checkOutput("ar_no_m1_ack_after", m1_ack, 0);
    applyStimulus(1, 1'b1, 1'b0, 6'h08, 32'h0, 4'hF);
    tick();
    checkOutput("ar_new_s_cs", s_cs, 1);
    checkOutput("ar_new_s_addr", s_addr, 32'h08);
    s_ack = 1'b1; s_rdata = 32'h0BAD_F00D;
    tick();
    checkOutput("ar_new_m1_ack", m1_ack, 1);
    checkOutput("ar_new_m1_err", m1_err, 0);
    checkOutput("ar_new_m1_rdata", m1_rdata, 32'h0BAD_F00D);
    checkOutput("ar_new_m0_ack", m0_ack, 0);
    s_ack = 1'b0; m1_cs = 1'b0;
    tick();
    checkOutput("ar_new_idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
